// File: rtl/debounce_pkg.sv
// ----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the button debouncer: the FSM state encoding, the
// default stability window and the width of the stable-sample counter.
// ----------------------------------------------------------------------------
package debounce_pkg;

  // Default number of consecutive identical samples needed to accept a level.
  localparam int unsigned DEFAULT_STABLE = 32'd4;

  // Width of the stable-sample counter (covers STABLE_CYCLES up to 65535).
  localparam int unsigned CNT_W = 32'd16;

  // Debouncer FSM states. Bit 1 is the currently accepted level and bit 0
  // marks a pending (being-qualified) transition.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

endpackage : debounce_pkg

// File: rtl/button_debouncer_sync2.sv
// ----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer that brings the raw asynchronous button into the clk
// domain. Both flops clear to 0 on reset.
//
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-low reset
//   d   - asynchronous input
//   q   - synchronized output (second flop)
// ----------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage shift; the first stage may go metastable, the second absorbs it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule : sync2

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
// Debounces a raw pushbutton. The button is synchronized, then a four-state
// FSM requires STABLE_CYCLES consecutive identical synchronized samples before
// accepting a new level. Accepted transitions produce one-cycle rise/fall
// pulses and rising edges are counted in an 8-bit wrapping counter.
//
// Parameters:
//   STABLE_CYCLES - consecutive identical samples to accept a level (2..65535)
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   btn       - raw asynchronous button input
//   level     - registered debounced level
//   level_n   - registered complement of level
//   rise      - one-cycle pulse on accepted 0->1
//   fall      - one-cycle pulse on accepted 1->0
//   press_cnt - number of accepted rises, wraps 255 -> 0
// ----------------------------------------------------------------------------
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       level,
  output logic       level_n,
  output logic       rise,
  output logic       fall,
  output logic [7:0] press_cnt
);

  // Counter value on the sample that completes the stability window. The
  // first differing sample already loads 1, so acceptance happens when the
  // counter holds STABLE_CYCLES-1 and one more agreeing sample arrives.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s_s;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             level_n_r;
  logic             rise_r;
  logic             fall_r;
  logic [7:0]       press_cnt_r;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (s_s)
  );

  // Debounce FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE_LOW;
      cnt_r       <= CNT_ZERO;
      level_r     <= 1'b0;
      level_n_r   <= 1'b1;
      rise_r      <= 1'b0;
      fall_r      <= 1'b0;
      press_cnt_r <= 8'd0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        IDLE_LOW: begin
          if (s_s) begin
            state_r <= WAIT_HIGH;
            cnt_r   <= CNT_ONE;
          end else begin
            cnt_r   <= CNT_ZERO;
          end
        end
        WAIT_HIGH: begin
          if (s_s) begin
            if (cnt_r == LAST_CNT) begin
              state_r     <= IDLE_HIGH;
              level_r     <= 1'b1;
              level_n_r   <= 1'b0;
              rise_r      <= 1'b1;
              cnt_r       <= CNT_ZERO;
              press_cnt_r <= press_cnt_r + 8'd1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            // Glitch: fall back without touching the accepted level.
            state_r <= IDLE_LOW;
            cnt_r   <= CNT_ZERO;
          end
        end
        IDLE_HIGH: begin
          if (!s_s) begin
            state_r <= WAIT_LOW;
            cnt_r   <= CNT_ONE;
          end else begin
            cnt_r   <= CNT_ZERO;
          end
        end
        WAIT_LOW: begin
          if (!s_s) begin
            if (cnt_r == LAST_CNT) begin
              state_r   <= IDLE_LOW;
              level_r   <= 1'b0;
              level_n_r <= 1'b1;
              fall_r    <= 1'b1;
              cnt_r     <= CNT_ZERO;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            state_r <= IDLE_HIGH;
            cnt_r   <= CNT_ZERO;
          end
        end
        default: begin
          state_r   <= IDLE_LOW;
          cnt_r     <= CNT_ZERO;
          level_r   <= 1'b0;
          level_n_r <= 1'b1;
        end
      endcase
    end
  end

  assign level     = level_r;
  assign level_n   = level_n_r;
  assign rise      = rise_r;
  assign fall      = fall_r;
  assign press_cnt = press_cnt_r;

endmodule : button_debouncer

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES SHALL be: default 4, valid range 2..65535, the number of consecutive identical synchronized samples needed to accept a new level.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be: input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-004 Port btn SHALL be: input, 1 bit, raw asynchronous pushbutton/switch signal.
REQ-005 Port level SHALL be: output, 1 bit, registered debounced level; drives downstream DFFr d.
REQ-006 Port level_n SHALL be: output, 1 bit, registered complement of level.
REQ-007 Port rise SHALL be: output, 1 bit, registered single-cycle pulse when level goes 0->1.
REQ-008 Port fall SHALL be: output, 1 bit, registered single-cycle pulse when level goes 1->0.
REQ-009 Port press_cnt SHALL be: output, 8 bits, count of accepted rise events.

Function
REQ-010 btn SHALL pass through a two-flop synchronizer; s = second stage; the FSM samples only s.
REQ-011 FSM states SHALL be IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW; the stable counter cnt is 16 bits.
REQ-012 In IDLE_LOW with s=1, the FSM SHALL go to WAIT_HIGH with cnt<=1; with s=0 it SHALL stay, cnt<=0.
REQ-013 In WAIT_HIGH with s=1 and cnt==STABLE_CYCLES-1, the FSM SHALL go to IDLE_HIGH, level<=1, level_n<=0, rise<=1, cnt<=0.
REQ-014 In WAIT_HIGH with s=1 and cnt<STABLE_CYCLES-1, the FSM SHALL stay and cnt<=cnt+1.
REQ-015 In WAIT_HIGH with s=0, the FSM SHALL return to IDLE_LOW with cnt<=0 and level unchanged (glitch rejected).
REQ-016 IDLE_HIGH/WAIT_LOW SHALL mirror REQ-012..015 with s polarity inverted, setting level<=0, level_n<=1, fall<=1 on acceptance.
REQ-017 rise and fall SHALL each be high exactly one cycle per accepted transition and SHALL never be high together.
REQ-018 Latency SHALL be STABLE_CYCLES+2 rising edges from the first edge sampling btn at its new value to level changing, provided btn holds.
REQ-019 press_cnt SHALL increment by 1 on the same edge rise is set, wrapping 255->0.
REQ-020 level_n SHALL equal ~level in every cycle, including during reset.

Reset
REQ-021 While rst=0, the block SHALL asynchronously set the sync flops to 0, state to IDLE_LOW, cnt 0, level 0, level_n 1, rise 0, fall 0, and press_cnt 0.
REQ-022 Reset asserted mid-WAIT SHALL discard the partial count; no rise or fall pulse is generated for the aborted transition.
REQ-023 After rst deasserts with btn held high, the block SHALL treat it as a press (rise after STABLE_CYCLES+2 edges).

Structure
REQ-024 Package debounce_pkg SHALL hold the state enum/encoding, DEFAULT_STABLE=4, and CNT_W=16.
REQ-025 The synchronizer SHALL be sub-module sync2 (clk, rst, d, q; two flops, async active-low reset to 0).

Verification (STABLE_CYCLES=4)
REQ-026 Reset then btn=1 held -> level=1, rise pulse 1 cycle, 6 edges after the first edge sampling btn=1; press_cnt=1.
REQ-027 btn high for 3 cycles then low -> level stays 0; no rise; press_cnt=0.
REQ-028 btn bounce 1,0,1,0 per cycle, then steady 1 -> single rise only after 4 stable s samples; press_cnt increments once.
REQ-029 level=1, btn=0 held -> fall pulse 1 cycle at 6 edges; level=0, level_n=1; press_cnt unchanged.
REQ-030 rst pulsed low during WAIT_HIGH (cnt=2) -> all outputs at reset values immediately; no pulse follows.
REQ-031 256 clean presses -> press_cnt reads 255 after the 255th and 0 after the 256th.
